// File: rtl/dispatcher_pkg.sv
// Shared types and sizing for the dispatcher rename stage.
// No logic; latency and backpressure are defined by the modules that import it.
// Tag width must track the free-tag FIFO.
package dispatcher_pkg;

    localparam int TAG_W    = 6;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = $clog2(NUM_REGS);

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rst_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HAVE = 2'd2
    } tag_fsm_e;

endpackage

// File: rtl/register_status_table_if.sv
// Dispatch-side bundle: instruction presented to the rename stage and its lookup results.
// Purely combinational handshake; master is the dispatcher, slave is the table.
// disp_ready is the only backpressure signal.
interface register_status_table_if
    import dispatcher_pkg::*;
();
    logic             disp_valid;
    logic             disp_rd_we;
    logic [REG_W-1:0] disp_rd;
    logic [REG_W-1:0] disp_rs1;
    logic [REG_W-1:0] disp_rs2;
    logic             disp_ready;
    logic [TAG_W-1:0] rd_tag;
    logic             rs1_busy;
    logic             rs2_busy;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;

    modport master (
        output disp_valid, disp_rd_we, disp_rd, disp_rs1, disp_rs2,
        input  disp_ready, rd_tag, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );

    modport slave (
        input  disp_valid, disp_rd_we, disp_rd, disp_rs1, disp_rs2,
        output disp_ready, rd_tag, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );
endinterface

// File: rtl/tag_prefetch.sv
// Keeps one free tag staged ahead of dispatch so renames can fire every cycle.
// Latency: tag usable the cycle after the pull (WAIT), then held in HAVE until consumed.
// Backpressure: tag_available low in IDLE; freeze holds state and suppresses pulls.
module tag_prefetch
    import dispatcher_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] fl_tag,
    input  logic             fl_empty,
    input  logic             consume,
    input  logic             freeze,
    output logic             fl_pull,
    output logic             tag_available,
    output logic [TAG_W-1:0] rd_tag
);

    tag_fsm_e         state_q, state_nxt;
    logic [TAG_W-1:0] held_q, held_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_nxt;
            held_q  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        held_nxt      = held_q;
        fl_pull       = 1'b0;
        tag_available = 1'b0;
        rd_tag        = held_q;
        case (state_q)
            IDLE: begin
                fl_pull = !fl_empty;
                if (fl_pull) state_nxt = WAIT;
            end
            WAIT: begin
                tag_available = 1'b1;
                rd_tag        = fl_tag;
                if (consume) begin
                    fl_pull   = !fl_empty;
                    state_nxt = fl_pull ? WAIT : IDLE;
                end else begin
                    // fl_tag is only guaranteed this cycle, so capture it
                    held_nxt  = fl_tag;
                    state_nxt = HAVE;
                end
            end
            HAVE: begin
                tag_available = 1'b1;
                if (consume) begin
                    fl_pull   = !fl_empty;
                    state_nxt = fl_pull ? WAIT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Flush leaves the staged tag in place so it is not leaked
        if (rst || freeze) begin
            fl_pull   = 1'b0;
            state_nxt = state_q;
            held_nxt  = held_q;
        end
        if (rst) tag_available = 1'b0;
    end

endmodule

// File: rtl/register_status_table.sv
// Rename table: per-register {busy, tag}, source lookup with CDB bypass, destination rename.
// Latency: lookups and disp_ready are combinational; table writes visible the next cycle.
// Backpressure: disp_ready drops on flush, reset, or a rename with no staged tag.
module register_status_table
    import dispatcher_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    register_status_table_if.slave  disp,
    input  logic [TAG_W-1:0]        fl_tag,
    input  logic                    fl_empty,
    output logic                    fl_pull,
    input  logic                    cdb_valid,
    input  logic [TAG_W-1:0]        cdb_tag,
    input  logic                    flush
);

    rst_entry_t       rat_q [NUM_REGS];
    rst_entry_t       src1, src2;
    logic             rename, fire, consume, tag_available;
    logic [TAG_W-1:0] new_tag;

    assign rename  = disp.disp_valid && disp.disp_rd_we && (disp.disp_rd != '0);
    assign disp.disp_ready = !rst && !flush && (!rename || tag_available);
    assign fire    = disp.disp_valid && disp.disp_ready;
    assign consume = fire && rename;
    assign disp.rd_tag = new_tag;

    tag_prefetch u_prefetch (
        .clk           (clk),
        .rst           (rst),
        .fl_tag        (fl_tag),
        .fl_empty      (fl_empty),
        .consume       (consume),
        .freeze        (flush),
        .fl_pull       (fl_pull),
        .tag_available (tag_available),
        .rd_tag        (new_tag)
    );

    // Lookups read the pre-edge table, so rs == rd returns the old mapping
    assign src1 = rat_q[disp.disp_rs1];
    assign src2 = rat_q[disp.disp_rs2];

    assign disp.rs1_busy = (disp.disp_rs1 != '0) && src1.busy && !(cdb_valid && (cdb_tag == src1.tag));
    assign disp.rs2_busy = (disp.disp_rs2 != '0) && src2.busy && !(cdb_valid && (cdb_tag == src2.tag));
    assign disp.rs1_tag  = src1.tag;
    assign disp.rs2_tag  = src2.tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (flush) begin
                    rat_q[i].busy <= 1'b0;
                end else begin
                    if (cdb_valid && rat_q[i].busy && (rat_q[i].tag == cdb_tag))
                        rat_q[i].busy <= 1'b0;
                    // Later assignment lets a same-cycle rename override the CDB clear
                    if (consume && (disp.disp_rd == REG_W'(i)))
                        rat_q[i] <= '{busy: 1'b1, tag: new_tag};
                end
            end
        end
    end

endmodule

// File: tb/tb_register_status_table.sv
// Scenario bench for register_status_table with a small free-tag FIFO model.
module tb_register_status_table;
    import dispatcher_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [TAG_W-1:0] fl_tag;
    logic             fl_empty;
    logic             fl_pull;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             flush;

    register_status_table_if bus ();

    register_status_table dut (
        .clk       (clk),
        .rst       (rst),
        .disp      (bus),
        .fl_tag    (fl_tag),
        .fl_empty  (fl_empty),
        .fl_pull   (fl_pull),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    // Free-tag FIFO model with registered output
    logic [TAG_W-1:0] mem [64];
    int               wr_ptr = 0;
    int               rd_ptr;
    assign fl_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 0;
            fl_tag <= '0;
        end else if (fl_pull && (wr_ptr != rd_ptr)) begin
            fl_tag <= mem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int               vectors    = 0;
    int               miscompares = 0;
    logic [TAG_W-1:0] exp_q [$];
    logic [TAG_W-1:0] exp_tag;

    task automatic push_tag(input logic [TAG_W-1:0] t);
        mem[wr_ptr[5:0]] = t;
        wr_ptr++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.disp_valid = v;
        bus.disp_rd_we = we;
        bus.disp_rd    = rd;
        bus.disp_rs1   = r1;
        bus.disp_rs2   = r2;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        push_tag(6'd0); push_tag(6'd1); push_tag(6'd2);
        tick(); tick();
        vectors++;
        if (bus.disp_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", bus.disp_ready); end
        vectors++;
        if (fl_pull !== 1'b0) begin miscompares++; $display("FAIL reset_pull: got %b expected 0", fl_pull); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b0;
        drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        #1;
        vectors++;
        if (fl_pull !== 1'b1) begin miscompares++; $display("FAIL c1_pull: got %b expected 1", fl_pull); end
        vectors++;
        if (bus.disp_ready !== 1'b0) begin miscompares++; $display("FAIL c1_ready: got %b expected 0", bus.disp_ready); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 5'(5 + k), 5'd0, 5'd0);
            exp_q.push_back(6'(k));
            #1;
            vectors++;
            if (bus.disp_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, bus.disp_ready); end
            exp_tag = exp_q.pop_front();
            vectors++;
            if (bus.rd_tag !== exp_tag) begin miscompares++; $display("FAIL b2b_tag[%0d]: got %0d expected %0d", k, bus.rd_tag, exp_tag); end
            vectors++;
            if (fl_pull !== (k < 2)) begin miscompares++; $display("FAIL b2b_pull[%0d]: got %b expected %b", k, fl_pull, k < 2); end
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 5'd5, 5'd6);
        #1;
        vectors++;
        if ({bus.rs1_busy, bus.rs1_tag, bus.rs2_busy, bus.rs2_tag} !== {1'b1, 6'd0, 1'b1, 6'd1}) begin
            miscompares++; $display("FAIL b2b_r5r6: got %b/%0d %b/%0d expected 1/0 1/1", bus.rs1_busy, bus.rs1_tag, bus.rs2_busy, bus.rs2_tag);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
        #1;
        vectors++;
        if ({bus.rs1_busy, bus.rs1_tag, bus.rs2_busy} !== {1'b1, 6'd2, 1'b0}) begin
            miscompares++; $display("FAIL b2b_r7r0: got %b/%0d %b expected 1/2 0", bus.rs1_busy, bus.rs1_tag, bus.rs2_busy);
        end
        tick();
    endtask

    task automatic test_cdb_bypass();
        push_tag(6'd3);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        exp_q.push_back(6'd3);
        #1;
        exp_tag = exp_q.pop_front();
        vectors++;
        if (bus.disp_ready !== 1'b1 || bus.rd_tag !== exp_tag) begin
            miscompares++; $display("FAIL cdb_setup: got ready %b tag %0d expected 1 %0d", bus.disp_ready, bus.rd_tag, exp_tag);
        end
        tick();
        cdb_valid = 1'b1; cdb_tag = 6'd3;
        drive(1'b0, 1'b0, 5'd0, 5'd5, 5'd6);
        #1;
        vectors++;
        if ({bus.rs1_busy, bus.rs1_tag, bus.rs2_busy} !== {1'b0, 6'd3, 1'b1}) begin
            miscompares++; $display("FAIL cdb_bypass: got %b/%0d %b expected 0/3 1", bus.rs1_busy, bus.rs1_tag, bus.rs2_busy);
        end
        tick();
        cdb_valid = 1'b0;
        #1;
        vectors++;
        if (bus.rs1_busy !== 1'b0) begin miscompares++; $display("FAIL cdb_cleared: got %b expected 0", bus.rs1_busy); end
        tick();
    endtask

    task automatic test_cdb_rename_same();
        push_tag(6'd3); push_tag(6'd9);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        exp_q.push_back(6'd3);
        #1;
        exp_tag = exp_q.pop_front();
        vectors++;
        if (bus.rd_tag !== exp_tag) begin miscompares++; $display("FAIL same_first_tag: got %0d expected %0d", bus.rd_tag, exp_tag); end
        tick();
        cdb_valid = 1'b1; cdb_tag = 6'd3;
        exp_q.push_back(6'd9);
        #1;
        exp_tag = exp_q.pop_front();
        vectors++;
        if (bus.disp_ready !== 1'b1 || bus.rd_tag !== exp_tag) begin
            miscompares++; $display("FAIL same_second_tag: got ready %b tag %0d expected 1 %0d", bus.disp_ready, bus.rd_tag, exp_tag);
        end
        tick();
        cdb_valid = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
        #1;
        vectors++;
        if ({bus.rs1_busy, bus.rs1_tag} !== {1'b1, 6'd9}) begin
            miscompares++; $display("FAIL same_rename_wins: got %b/%0d expected 1/9", bus.rs1_busy, bus.rs1_tag);
        end
        tick();
    endtask

    task automatic test_same_cycle_rs_rd();
        push_tag(6'd2); push_tag(6'd10);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
        exp_q.push_back(6'd2);
        #1;
        exp_tag = exp_q.pop_front();
        vectors++;
        if (bus.rd_tag !== exp_tag) begin miscompares++; $display("FAIL rsrd_setup: got %0d expected %0d", bus.rd_tag, exp_tag); end
        tick();
        drive(1'b1, 1'b1, 5'd4, 5'd4, 5'd0);
        exp_q.push_back(6'd10);
        #1;
        vectors++;
        if ({bus.rs1_busy, bus.rs1_tag} !== {1'b1, 6'd2}) begin
            miscompares++; $display("FAIL rsrd_old_map: got %b/%0d expected 1/2", bus.rs1_busy, bus.rs1_tag);
        end
        exp_tag = exp_q.pop_front();
        vectors++;
        if (bus.rd_tag !== exp_tag) begin miscompares++; $display("FAIL rsrd_new_tag: got %0d expected %0d", bus.rd_tag, exp_tag); end
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd4, 5'd0);
        #1;
        vectors++;
        if ({bus.rs1_busy, bus.rs1_tag} !== {1'b1, 6'd10}) begin
            miscompares++; $display("FAIL rsrd_after: got %b/%0d expected 1/10", bus.rs1_busy, bus.rs1_tag);
        end
        tick();
    endtask

    task automatic test_empty_in_have();
        push_tag(6'd20);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        drive(1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        #1;
        vectors++;
        if (bus.disp_ready !== 1'b1 || fl_pull !== 1'b0) begin
            miscompares++; $display("FAIL have_store: got ready %b pull %b expected 1 0", bus.disp_ready, fl_pull);
        end
        tick();
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        vectors++;
        if (bus.disp_ready !== 1'b1) begin miscompares++; $display("FAIL have_rd0: got %b expected 1", bus.disp_ready); end
        tick();
        drive(1'b1, 1'b1, 5'd8, 5'd0, 5'd0);
        exp_q.push_back(6'd20);
        #1;
        exp_tag = exp_q.pop_front();
        vectors++;
        if (bus.disp_ready !== 1'b1 || bus.rd_tag !== exp_tag) begin
            miscompares++; $display("FAIL have_last_tag: got ready %b tag %0d expected 1 %0d", bus.disp_ready, bus.rd_tag, exp_tag);
        end
        tick();
        drive(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
        #1;
        vectors++;
        if (bus.disp_ready !== 1'b0 || fl_pull !== 1'b0) begin
            miscompares++; $display("FAIL empty_block: got ready %b pull %b expected 0 0", bus.disp_ready, fl_pull);
        end
        tick();
        drive(1'b1, 1'b0, 5'd9, 5'd0, 5'd0);
        #1;
        vectors++;
        if (bus.disp_ready !== 1'b1) begin miscompares++; $display("FAIL empty_store: got %b expected 1", bus.disp_ready); end
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd8, 5'd9);
        #1;
        vectors++;
        if ({bus.rs1_busy, bus.rs1_tag, bus.rs2_busy} !== {1'b1, 6'd20, 1'b0}) begin
            miscompares++; $display("FAIL empty_table: got %b/%0d %b expected 1/20 0", bus.rs1_busy, bus.rs1_tag, bus.rs2_busy);
        end
        tick();
    endtask

    task automatic test_flush();
        push_tag(6'd30); push_tag(6'd31); push_tag(6'd32); push_tag(6'd12);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 5'(1 + k), 5'd0, 5'd0);
            exp_q.push_back(6'(30 + k));
            #1;
            exp_tag = exp_q.pop_front();
            vectors++;
            if (bus.rd_tag !== exp_tag) begin miscompares++; $display("FAIL flush_setup[%0d]: got %0d expected %0d", k, bus.rd_tag, exp_tag); end
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        flush = 1'b1;
        drive(1'b1, 1'b1, 5'd10, 5'd1, 5'd2);
        #1;
        vectors++;
        if (bus.disp_ready !== 1'b0 || fl_pull !== 1'b0) begin
            miscompares++; $display("FAIL flush_block: got ready %b pull %b expected 0 0", bus.disp_ready, fl_pull);
        end
        tick();
        flush = 1'b0;
        exp_q.push_back(6'd12);
        #1;
        vectors++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            miscompares++; $display("FAIL flush_clear: got %b %b expected 0 0", bus.rs1_busy, bus.rs2_busy);
        end
        exp_tag = exp_q.pop_front();
        vectors++;
        if (bus.disp_ready !== 1'b1 || bus.rd_tag !== exp_tag) begin
            miscompares++; $display("FAIL flush_tag_kept: got ready %b tag %0d expected 1 %0d", bus.disp_ready, bus.rd_tag, exp_tag);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd3, 5'd10);
        #1;
        vectors++;
        if ({bus.rs1_busy, bus.rs2_busy, bus.rs2_tag} !== {1'b0, 1'b1, 6'd12}) begin
            miscompares++; $display("FAIL flush_after: got %b %b/%0d expected 0 1/12", bus.rs1_busy, bus.rs2_busy, bus.rs2_tag);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_cdb_bypass();
        test_cdb_rename_same();
        test_same_cycle_rs_rd();
        test_empty_in_have();
        test_flush();
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_status_table.md
# register_status_table

Rename stage of the dispatcher, directly downstream of the free-tag FIFO. It holds one {busy, tag} entry per architectural register and answers source-operand lookups for the instruction being dispatched. It renames the destination register with a tag prefetched from the free-tag FIFO. Entries are released when the CDB broadcasts the producing tag.

## Interface
- NUM_REGS, 32, number of architectural registers; register 0 is never renamed.
- TAG_W, 6, tag width; must match the free-tag FIFO.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- disp_valid  in  1  dispatcher presents an instruction.
- disp_rd_we  in  1  instruction writes a destination register.
- disp_rd  in  5  destination register index.
- disp_rs1, disp_rs2  in  5 each  source register indices.
- disp_ready  out  1  instruction can be accepted this cycle.
- rd_tag  out  TAG_W  tag allocated to disp_rd; valid when a renaming dispatch fires.
- rs1_busy, rs2_busy  out  1 each  source value is still pending.
- rs1_tag, rs2_tag  out  TAG_W each  producer tag; meaningful only when the matching busy bit is 1.
- fl_tag  in  TAG_W  registered tag output of the free-tag FIFO.
- fl_empty  in  1  free-tag FIFO is empty.
- fl_pull  out  1  pull request to the free-tag FIFO.
- cdb_valid  in  1  CDB broadcast is valid.
- cdb_tag  in  TAG_W  tag being broadcast.
- flush  in  1  clear all busy bits (mispredict recovery).

## Operation
- Renaming dispatch ("rename"): disp_valid & disp_rd_we & (disp_rd != 0).
- Fire: disp_valid & disp_ready.
- disp_ready = !flush & (!rename | tag_available).
- Tag prefetch FSM:
  - IDLE: no tag held; fl_pull = !fl_empty. If pulled, go to WAIT; otherwise stay in IDLE.
  - WAIT: fl_tag is valid this cycle and tag_available = 1; rd_tag = fl_tag.
  - HAVE: tag_available = 1; rd_tag = held register.
  - In WAIT or HAVE, fire with rename consumes the tag. fl_pull = !fl_empty. Next state is WAIT if pulled, otherwise IDLE.
  - In WAIT without consumption, latch fl_tag into the held register and go to HAVE.
  - In HAVE without consumption, stay in HAVE.
- Source lookup is combinational: rsN_busy = entry.busy & !(cdb_valid & cdb_tag == entry.tag), and rsN_tag = entry.tag. A source index of 0 always reads busy = 0.
- A source equal to disp_rd in the same cycle returns the pre-rename mapping.
- On a fire with rename, at the clock edge: entry[disp_rd] <= {busy 1, rd_tag}.
- On CDB, every entry with busy & tag == cdb_tag clears busy; the tag field is retained.
- Simultaneous events:
  - CDB clear and rename of the same register: the rename wins (busy = 1, new tag).
  - flush: all busy bits clear and the dispatch is blocked (disp_ready = 0). The FSM state and held tag are unchanged, so the tag is not leaked.
  - flush together with CDB: flush dominates.
- Non-renaming dispatches (disp_rd_we = 0 or rd = 0) fire regardless of FSM state and change no entry.
- Reset values: all busy = 0, all tags = 0, FSM = IDLE, held tag = 0. Outputs disp_ready = 0 and fl_pull = 0 while rst is high.

## Timing
- Lookup outputs, disp_ready and rd_tag are combinational from current state and inputs. Table updates are visible the cycle after the edge.
- fl_pull is asserted in the cycle of the request. fl_tag is sampled in the following cycle (WAIT).
- Throughput: with the FIFO non-empty, one renaming dispatch per cycle, sustained.
- Latency: first ready cycle after rst deasserts is cycle 2 (IDLE pull, then WAIT).
- fl_empty rising mid-stream: the FSM returns to IDLE after the last tag is consumed, and disp_ready drops for renaming dispatches only.
- rst mid-operation: an in-flight pulled tag is discarded. The free-tag FIFO resets in the same cycle, so ownership stays consistent.

## Structure
- Shared package dispatcher_pkg holds:
  - TAG_W and NUM_REGS.
  - rst_entry_t (packed struct: busy, tag).
  - tag_fsm_e enum (IDLE, WAIT, HAVE).
- Sub-module tag_prefetch contains the FSM, the held register, fl_pull and the tag_available/rd_tag generation. The top level holds the table, lookup, CDB match and flush.

## Test plan
- Reset, then fl_empty = 0 with fl_tag = 0, 1, 2…:
  - Expect fl_pull in cycle 1 and disp_ready in cycle 2.
  - Three back-to-back dispatches with rd = 5, 6, 7 get rd_tag 0, 1, 2.
  - The busy bits of r5, r6 and r7 are set.
- r5 busy with tag 3; in the same cycle cdb_valid with cdb_tag = 3 and a lookup of rs1 = 5:
  - Expect rs1_busy = 0.
  - Next cycle, entry[5].busy = 0.
- Same cycle: CDB with tag 3 (owner r5) and rename of r5 to tag 9 → entry[5] = {1, 9}.
- Dispatch with rd = 4, rs1 = 4, where r4 previously held tag 2 and is busy → rs1_tag = 2, rs1_busy = 1; after the edge, entry[4].tag = the new tag.
- fl_empty = 1 while in HAVE:
  - One rename fires; the next rename sees disp_ready = 0.
  - A store (disp_rd_we = 0) still fires.
  - A rename with rd = 0 fires without consuming a tag.
- Flush with r1–r3 busy while in HAVE with tag 12 → all busy bits = 0; the next rename receives tag 12.
